booth_pp_accumulator: RTL and testbench

Sequential consumer for the radix-4 Booth partial-product generator. Accepts one Booth partial product per beat over a valid/ready handshake, least-significant digit first. Each beat is corrected with its negate bit, weighted by 4^k and summed into a signed product. Sits between the per-digit partial-product generators and the multiplier result register. Optionally checks the generator's sign-extension bit for consistency.

---
 rtl/booth_pp_accumulator.sv | 123 ++++++++++++
 tb/tb_booth_pp_accumulator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : booth_pp_accumulator
//  Summary  : Sequential accumulator for radix-4 Booth partial products.
//             Takes one (pp, n, e) beat per accepted handshake, least-
//             significant digit first. Each beat is corrected by its negate
//             bit and weighted by 4^k. After D = M/2 beats the sum is
//             registered on product and presented on a valid/ready port.
//  Options  : PP_ACC_CHK_EN - when defined, every accepted beat checks
//             e == ~pp[N] and sets the sticky err flag on a mismatch.
//             When undefined, err is tied low and e is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module booth_pp_accumulator #(
    parameter int N = 4,               // multiplicand width
    parameter int M = 4                // multiplier width (even)
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active low
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N:0]       pp,
    input  logic             n,
    input  logic             e,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   product,
    output logic             err
);

    localparam int W  = N + M;
    localparam int D  = M / 2;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(D - 1);

    localparam logic [0:0] S_ACC = 1'b0;
    localparam logic [0:0] S_OUT = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;
    logic          accept;
    logic          last_beat;
    logic [W-1:0]  beat_ext;
    logic [W-1:0]  beat_shifted;
    logic [W-1:0]  sum;

    // Beat correction and weighting: sign-extend pp, add the negate bit,
    // then shift by two bits per digit position. All arithmetic wraps mod 2^W.
    assign accept       = in_valid & in_ready;
    assign last_beat    = (cnt == LAST_DIGIT);
    assign beat_ext     = {{(W-N-1){pp[N]}}, pp} + W'(n);
    assign beat_shifted = beat_ext << {cnt, 1'b0};
    assign sum          = acc + beat_shifted;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave ACC on the last digit, leave OUT on handshake
    always_comb begin
        state_next = state;
        case (state)
            S_ACC:   if (accept && last_beat) state_next = S_OUT;
            S_OUT:   if (out_ready)           state_next = S_ACC;
            default: state_next = S_ACC;
        endcase
    end

    // Output decode: beats are only taken while accumulating, so the
    // handshake cycle of OUT never swallows the next digit 0.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_ACC:   in_ready  = 1'b1;
            S_OUT:   out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath: accumulate beats, hand the final sum to product and clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            if (last_beat) begin
                product <= sum;
                acc     <= '0;
                cnt     <= '0;
            end else begin
                acc     <= sum;
                cnt     <= cnt + CW'(1);
            end
        end
    end

`ifdef PP_ACC_CHK_EN
    // Sticky sign-extension check: a valid generator always drives e = ~pp[N]
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (accept && (e != ~pp[N])) begin
            err <= 1'b1;
        end
    end
`else
    // Check disabled: err is constant and e has no function
    logic unused_chk;
    assign unused_chk = e;
    assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_booth_pp_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_pp_accumulator
//  Summary  : Self-checking bench for booth_pp_accumulator. Directed cases
//             plus random multiplicand/multiplier pairs; expected products
//             come from plain signed multiplication of the operands.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_booth_pp_accumulator;

    localparam int N = 4;
    localparam int M = 4;
    localparam int W = N + M;
    localparam int D = M / 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N:0]   pp;
    logic         n;
    logic         e;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] product;
    logic         err;

    int n_tests;
    int n_fail;
    logic exp_err;

    logic [N:0] bp [D];
    logic       bn [D];
    logic       be [D];

    booth_pp_accumulator #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp        (pp),
        .n         (n),
        .e         (e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: the product is simply x * multiplier, wrapped to W bits
    function automatic logic [W-1:0] ref_product(input logic [N-1:0] x, input logic [M-1:0] mul);
        int xs;
        int ms;
        int p;
        logic [31:0] pv;
        xs = $signed(x);
        ms = $signed(mul);
        p  = xs * ms;
        pv = p;
        return pv[W-1:0];
    endfunction

    // Emulates the upstream Booth generator to build a beat sequence
    task automatic booth_encode(input logic [N-1:0] x, input logic [M-1:0] mul);
        logic [M:0] ext;
        logic [2:0] code;
        logic [N:0] mag;
        ext = {mul, 1'b0};
        for (int k = 0; k < D; k++) begin
            code = ext[2*k +: 3];
            case (code)
                3'b001, 3'b010, 3'b101, 3'b110: mag = {x[N-1], x};
                3'b011, 3'b100:                 mag = {x, 1'b0};
                default:                        mag = '0;
            endcase
            bp[k] = code[2] ? ~mag : mag;
            bn[k] = code[2];
            be[k] = ~bp[k][N];
        end
    endtask

    // Runs one full product; phase: called and returns at a negedge
    task automatic run_product(input logic [W-1:0] exp, input int gap, input int hold, input bit garbage);
        for (int k = 0; k < D; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    check("idle_out_valid", out_valid, 0);
                end
            end
            in_valid = 1'b1;
            pp = bp[k];
            n  = bn[k];
            e  = be[k];
            check("beat_in_ready", in_ready, 1);
`ifdef PP_ACC_CHK_EN
            if (be[k] != ~bp[k][N]) exp_err = 1'b1;
`endif
            @(negedge clk);
            in_valid = 1'b0;
            check("beat_err", err, exp_err);
            if (k < D - 1) check("mid_out_valid", out_valid, 0);
        end
        check("out_valid", out_valid, 1);
        check("out_in_ready", in_ready, 0);
        check("product", product, exp);
        if (garbage) begin
            in_valid = 1'b1;
            pp = N'($urandom) + 1;
            n  = 1'($urandom);
            e  = 1'($urandom);
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_product", product, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_err", err, exp_err);
    endtask

    initial begin
        logic [N-1:0] x;
        logic [M-1:0] mul;
        n_tests   = 0;
        n_fail    = 0;
        exp_err   = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pp        = '0;
        n         = 1'b0;
        e         = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        @(negedge clk);

        // x = 3, multiplier = 5
        bp[0] = 5'b00011; bn[0] = 1'b0; be[0] = 1'b1;
        bp[1] = 5'b00011; bn[1] = 1'b0; be[1] = 1'b1;
        run_product(8'h0F, 0, 0, 0);

        // x = -8, multiplier = -8
        bp[0] = 5'b00000; bn[0] = 1'b0; be[0] = 1'b1;
        bp[1] = 5'b01111; bn[1] = 1'b1; be[1] = 1'b1;
        run_product(8'h40, 0, 0, 1);

        // x = -1, multiplier = 7, one idle cycle between beats
        bp[0] = 5'b00000; bn[0] = 1'b1; be[0] = 1'b1;
        bp[1] = 5'b11110; bn[1] = 1'b0; be[1] = 1'b0;
        run_product(8'hF9, 1, 0, 0);

        // Backpressure: three cycles with out_ready low, beats offered meanwhile
        booth_encode(4'd3, 4'd5);
        run_product(8'h0F, 0, 3, 1);

        // Reset in the middle of a product
        in_valid = 1'b1; pp = 5'b00011; n = 1'b0; e = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_product", product, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bp[0] = 5'b00001; bn[0] = 1'b0; be[0] = 1'b1;
        bp[1] = 5'b00000; bn[1] = 1'b0; be[1] = 1'b1;
        run_product(8'h01, 0, 0, 0);

        // Random operands, gaps, backpressure and ignored offers in OUT
        for (int t = 0; t < 40; t++) begin
            x   = N'($urandom);
            mul = M'($urandom);
            booth_encode(x, mul);
            run_product(ref_product(x, mul), $urandom_range(0, 2),
                        $urandom_range(0, 3), 1'($urandom));
        end

        // Inconsistent sign-extension bit; arithmetic must be unaffected
        bp[0] = 5'b00011; bn[0] = 1'b0; be[0] = 1'b0;
        bp[1] = 5'b00011; bn[1] = 1'b0; be[1] = 1'b1;
        run_product(8'h0F, 0, 0, 0);
        x = 4'hA; mul = 4'h6;
        booth_encode(x, mul);
        run_product(ref_product(x, mul), 1, 1, 0);

        // Reset clears the sticky flag
        rst = 1'b0;
        #1;
        exp_err = 1'b0;
        check("final_rst_err", err, exp_err);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
